// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It resolves three
// conditions in fixed priority order:
//   1. a data-memory access that is outstanding in MEM, which freezes the
//      whole pipeline;
//   2. a load-use hazard, which inserts one bubble into ID_EX;
//   3. a taken branch, which flushes IF_ID.
// It also keeps saturating stall/flush counters and raises a sticky error if
// the data memory never acknowledges a request.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   IF_ID_RS1addr_i/RS2   source registers of the instruction in ID
//   ID_EX_RDaddr_i        destination register of the instruction in EX
//   ID_EX_MemRead_i       the instruction in EX is a load
//   EX_MEM_MemRead_i      MEM holds a load
//   EX_MEM_MemWrite_i     MEM holds a store
//   Branch_taken_i        a branch resolved taken in ID this cycle
//   mem_ack_i             the data memory completes the current request
//   PCWrite_o             update enable for the PC
//   IF_ID_Write_o         update enable for IF_ID
//   IF_ID_Flush_o         load a NOP into IF_ID
//   ID_EX_Bubble_o        zero the control fields of ID_EX
//   pipe_stall_o          hold ID_EX, EX_MEM and MEM_WB
//   mem_req_o             data-memory request valid
//   error_o               sticky memory-timeout flag
//   stall_cnt_o           saturating count of stall and bubble cycles
//   flush_cnt_o           saturating count of flush cycles
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS1addr_i,
    input  logic [4:0]       IF_ID_RS2addr_i,
    input  logic [4:0]       ID_EX_RDaddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             EX_MEM_MemRead_i,
    input  logic             EX_MEM_MemWrite_i,
    input  logic             Branch_taken_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             pipe_stall_o,
    output logic             mem_req_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [TW-1:0]    r_tcnt;
    logic             w_mem_acc;
    logic             w_lu;
    logic             w_tmo;

    assign w_mem_acc = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
    assign w_lu      = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                       ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) ||
                        (ID_EX_RDaddr_i == IF_ID_RS2addr_i));
    // The last WAIT cycle before giving up.
    assign w_tmo     = (r_tcnt == TW'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; an ack wins over a timeout in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_mem_acc) w_next = mem_ack_i ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (mem_ack_i)  w_next = S_DONE;
                else if (w_tmo) w_next = S_ERR;
            end
            S_DONE: w_next = S_IDLE;
            S_ERR:  w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // WAIT-cycle counter: cleared when a request enters WAIT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_tcnt <= '0;
        else if (r_state == S_IDLE && w_mem_acc && !mem_ack_i)
            r_tcnt <= '0;
        else if (r_state == S_WAIT && !w_tmo)
            r_tcnt <= r_tcnt + TW'(1);
    end

    // Output logic. All controls are forced low while reset is held, because
    // an IDLE request term would otherwise depend on live inputs.
    always_comb begin
        PCWrite_o      = 1'b0;
        IF_ID_Write_o  = 1'b0;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        pipe_stall_o   = 1'b0;
        mem_req_o      = 1'b0;
        error_o        = 1'b0;
        if (rst_i) begin
            mem_req_o    = (r_state == S_WAIT) || (r_state == S_IDLE && w_mem_acc);
            pipe_stall_o = mem_req_o || (r_state == S_ERR);
            error_o      = (r_state == S_ERR);
            if (pipe_stall_o) begin
                // The whole pipe is frozen; hazards are re-evaluated after release.
            end else if (w_lu) begin
                ID_EX_Bubble_o = 1'b1;
            end else begin
                PCWrite_o     = 1'b1;
                IF_ID_Write_o = 1'b1;
                IF_ID_Flush_o = Branch_taken_i;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if ((pipe_stall_o || ID_EX_Bubble_o) && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (IF_ID_Flush_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enable, bubble and flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB. Handles three conditions: load-use hazards, taken-branch flushes, and a variable-latency data-memory handshake that freezes the whole pipeline while a MEM-stage access is outstanding. Also keeps saturating stall and flush counters and a sticky memory-timeout error.

## Interface
- TIMEOUT_CYC, 255: maximum WAIT-state cycles before the timeout error fires.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-low reset.
- IF_ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- IF_ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- ID_EX_RDaddr_i  in  5  rd of the instruction in EX.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- EX_MEM_MemRead_i  in  1  MEM stage holds a load.
- EX_MEM_MemWrite_i  in  1  MEM stage holds a store.
- Branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_ack_i  in  1  data memory completes the current request.
- PCWrite_o  out  1  PC register update enable.
- IF_ID_Write_o  out  1  IF_ID register update enable.
- IF_ID_Flush_o  out  1  IF_ID is loaded with a NOP.
- ID_EX_Bubble_o  out  1  ID_EX control fields are zeroed (bubble inserted).
- pipe_stall_o  out  1  freezes ID_EX, EX_MEM and MEM_WB (hold contents).
- mem_req_o  out  1  data-memory request valid.
- error_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of flush cycles.

## Operation
- Memory access signal: mem_acc = EX_MEM_MemRead_i | EX_MEM_MemWrite_i.
- FSM states are IDLE, WAIT, DONE and ERR. The reset state is IDLE.
- IDLE
  - If mem_acc: assert mem_req_o and pipe_stall_o.
    - mem_ack_i=1 → DONE.
    - mem_ack_i=0 → WAIT; clear the timeout counter.
  - Otherwise: no memory stall; stay in IDLE.
- WAIT
  - Assert mem_req_o and pipe_stall_o; the timeout counter increments each cycle.
  - mem_ack_i=1 → DONE. Ack has priority over timeout in the same cycle.
  - Counter reaches TIMEOUT_CYC-1 without ack → ERR; set error_o.
- DONE
  - mem_req_o=0, pipe_stall_o=0; the completed access leaves MEM.
  - Always → IDLE.
  - The access is never re-requested. A back-to-back access is seen in IDLE on the next cycle.
- ERR
  - mem_req_o=0; pipe_stall_o, PCWrite_o=0 and IF_ID_Write_o=0 are held.
  - Exit only via reset.
- Load-use hazard: lu = ID_EX_MemRead_i & (ID_EX_RDaddr_i≠0) & (ID_EX_RDaddr_i==IF_ID_RS1addr_i | ID_EX_RDaddr_i==IF_ID_RS2addr_i).
- Priority, evaluated combinationally every cycle:
  1. Memory stall (pipe_stall_o=1): PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=0, IF_ID_Flush_o=0. lu and Branch_taken_i are ignored; they are re-evaluated after release.
  2. lu: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, IF_ID_Flush_o=0. A simultaneous branch is suppressed; the branch re-resolves next cycle with forwarded data.
  3. Branch_taken_i: IF_ID_Flush_o=1, PCWrite_o=1, IF_ID_Write_o=1.
  4. Otherwise: PCWrite_o=1, IF_ID_Write_o=1, all other controls 0.
- stall_cnt_o increments on every cycle with pipe_stall_o=1 or an active lu bubble.
- flush_cnt_o increments on every cycle with IF_ID_Flush_o=1.
- Both counters saturate at 2^CNT_W-1; they do not wrap.

## Timing
- While rst_i=0, asynchronously:
  - PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, pipe_stall_o, mem_req_o and error_o are 0.
  - Counters are 0; state is IDLE; the timeout counter is 0.
- Reset asserted mid-WAIT or in ERR returns to IDLE immediately. The outstanding request is dropped.
- All control outputs are combinational from the current state and inputs. There is zero latency from a hazard condition to its stall/bubble/flush.
- Minimum memory access (ack in the first request cycle) costs exactly 1 stall cycle plus the DONE cycle.
- An access whose ack arrives N cycles after the request starts costs N+1 stall cycles.
- error_o rises on the clock edge after the timeout-th WAIT cycle and stays high until reset.
- mem_ack_i is ignored when mem_req_o=0.

## Test plan
- Reset, then idle inputs → PCWrite_o=1, IF_ID_Write_o=1, all other controls 0, counters 0.
- Load-use: ID_EX_MemRead_i=1, ID_EX_RDaddr_i=5, IF_ID_RS2addr_i=5 for 1 cycle → PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, stall_cnt_o=1. Repeat with rd=0 → no stall.
- Taken branch together with load-use (rd=3, rs1=3) → only the bubble, flush 0. Next cycle: branch alone → IF_ID_Flush_o=1, flush_cnt_o=1.
- Store in MEM, mem_ack_i returned 3 cycles after the request → pipe_stall_o high for 4 cycles, DONE for 1 cycle, stall_cnt_o=4. A branch during the stall is not flushed.
- Two back-to-back loads with immediate ack → stall, DONE, stall, DONE; exactly 2 requests issued.
- TIMEOUT_CYC=4 with no ack → error_o=1 after 4 WAIT cycles, pipe_stall_o stays 1. Reset → all outputs 0, then IDLE. Saturation check with CNT_W=2 → stall_cnt_o holds at 3.
